axilite_write_arbiter: RTL and testbench

//  Shares one AXI-Lite write master port (AW, W, B) between NUM_REQ write requesters

---
 rtl/axilite_write_arbiter_pkg.sv | 14 +
 rtl/axilite_write_arbiter_rr_picker.sv | 43 ++++
 rtl/axilite_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_axilite_write_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axilite_write_arbiter_pkg.sv
// Shared definitions for the AXI-Lite write arbiter: FSM state encoding and
// BRESP codes.
package axilite_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_B = 2'd2
  } arb_state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

endpackage

// File: rtl/axilite_write_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   eligible_i   : per-requester request vector
//   last_grant_i : index granted last; search starts just above it
//   grant_oh_o   : one-hot winner (zero when nothing is eligible)
//   grant_idx_o  : winner index
//   any_valid_o  : at least one requester is eligible
module axilite_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned GRANT_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [GRANT_W-1:0] last_grant_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [GRANT_W-1:0] grant_idx_o,
  output logic               any_valid_o
);

  // Two passes: indices above last_grant first, then wrap to 0..last_grant.
  always_comb begin
    int unsigned last_c;
    logic        found_c;
    last_c      = 32'(last_grant_i);
    found_c     = 1'b0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found_c && eligible_i[i] && (i > last_c)) begin
        found_c       = 1'b1;
        grant_oh_o[i] = 1'b1;
        grant_idx_o   = GRANT_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found_c && eligible_i[i] && (i <= last_c)) begin
        found_c       = 1'b1;
        grant_oh_o[i] = 1'b1;
        grant_idx_o   = GRANT_W'(i);
      end
    end
    any_valid_o = found_c;
  end

endmodule

// File: rtl/axilite_write_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite write master (AW/W/B) between
// NUM_REQ requesters, one transaction in flight.
//   s_aw*/s_w*/s_b*  : per-requester slave-side channels (payloads packed i*W +: W)
//   m_axi_*          : shared master port; AW/W address, data and valids registered
// Grant is combinational in IDLE; B channel is passed through to the granted
// requester while waiting for the response.
module axilite_write_arbiter
  import axilite_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ            = 2,
  parameter int unsigned AXILITE_ADDR_WIDTH = 48,
  parameter int unsigned AXILITE_DATA_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ*AXILITE_ADDR_WIDTH-1:0] s_awaddr,
  input  logic [NUM_REQ-1:0]                s_awvalid,
  output logic [NUM_REQ-1:0]                s_awready,
  input  logic [NUM_REQ*AXILITE_DATA_WIDTH-1:0] s_wdata,
  input  logic [NUM_REQ-1:0]                s_wvalid,
  output logic [NUM_REQ-1:0]                s_wready,
  output logic [1:0]                        s_bresp,
  output logic [NUM_REQ-1:0]                s_bvalid,
  input  logic [NUM_REQ-1:0]                s_bready,
  output logic [AXILITE_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [AXILITE_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready
);

  localparam int unsigned GRANT_W = $clog2(NUM_REQ);
  localparam int unsigned AW      = AXILITE_ADDR_WIDTH;
  localparam int unsigned DW      = AXILITE_DATA_WIDTH;

  arb_state_e          state_q, state_d;
  logic [GRANT_W-1:0]  grant_q, grant_d;
  logic [GRANT_W-1:0]  last_grant_q, last_grant_d;
  logic [AW-1:0]       awaddr_q, awaddr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;

  logic [NUM_REQ-1:0]  eligible_c;
  logic [NUM_REQ-1:0]  pick_oh_c;
  logic [GRANT_W-1:0]  pick_idx_c;
  logic                pick_any_c;
  logic                aw_done_c;
  logic                w_done_c;

  // Only requesters presenting both address and data compete.
  assign eligible_c = s_awvalid & s_wvalid;

  axilite_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_picker (
    .eligible_i   (eligible_c),
    .last_grant_i (last_grant_q),
    .grant_oh_o   (pick_oh_c),
    .grant_idx_o  (pick_idx_c),
    .any_valid_o  (pick_any_c)
  );

  // A channel counts as done once its valid is low or is being accepted now.
  assign aw_done_c = !awvalid_q || m_axi_awready;
  assign w_done_c  = !wvalid_q  || m_axi_wready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(NUM_REQ - 1);
      awaddr_q     <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
    end
  end

  // Next-state and handshake steering.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    s_awready    = '0;
    s_wready     = '0;
    s_bvalid     = '0;
    s_bresp      = BRESP_OKAY;
    m_axi_bready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // rst_n gating keeps the ready pulse quiet while reset is held.
        if (pick_any_c && rst_n) begin
          s_awready = pick_oh_c;
          s_wready  = pick_oh_c;
          grant_d   = pick_idx_c;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh_c[i]) begin
              awaddr_d = s_awaddr[i*AW +: AW];
              wdata_d  = s_wdata[i*DW +: DW];
            end
          end
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if (aw_done_c && w_done_c) state_d = ST_WAIT_B;
      end

      ST_WAIT_B: begin
        s_bresp = m_axi_bresp;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant_q == GRANT_W'(i)) begin
            m_axi_bready = s_bready[i];
            s_bvalid[i]  = m_axi_bvalid;
          end
        end
        if (m_axi_bvalid && m_axi_bready) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;

endmodule

// File: tb/tb_axilite_write_arbiter.sv
// Bench for axilite_write_arbiter: cycle vector table, a mid-transaction reset
// sequence, and a randomized phase checked against a transaction-level model.
module tb_axilite_write_arbiter;
  import axilite_write_arbiter_pkg::*;

  localparam int unsigned N       = 2;
  localparam int unsigned AW      = 48;
  localparam int unsigned DW      = 64;
  localparam int unsigned GRANT_W = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*AW-1:0]   s_awaddr;
  logic [N-1:0]      s_awvalid, s_awready;
  logic [N*DW-1:0]   s_wdata;
  logic [N-1:0]      s_wvalid, s_wready;
  logic [1:0]        s_bresp;
  logic [N-1:0]      s_bvalid, s_bready;
  logic [AW-1:0]     m_axi_awaddr;
  logic              m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]     m_axi_wdata;
  logic              m_axi_wvalid, m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid, m_axi_bready;

  axilite_write_arbiter #(
    .NUM_REQ            (N),
    .AXILITE_ADDR_WIDTH (AW),
    .AXILITE_DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_awaddr      (s_awaddr),
    .s_awvalid     (s_awvalid),
    .s_awready     (s_awready),
    .s_wdata       (s_wdata),
    .s_wvalid      (s_wvalid),
    .s_wready      (s_wready),
    .s_bresp       (s_bresp),
    .s_bvalid      (s_bvalid),
    .s_bready      (s_bready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int unsigned i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  logic [AW-1:0] req_addr [N];
  logic [DW-1:0] req_data [N];

  task automatic put_payload();
    for (int i = 0; i < N; i++) begin
      s_awaddr[i*AW +: AW] = req_addr[i];
      s_wdata[i*DW +: DW]  = req_data[i];
    end
  endtask

  task automatic drive(input logic [1:0] awv, input logic [1:0] wv, input logic [1:0] br,
                       input logic mawr, input logic mwr, input logic mbv,
                       input logic [1:0] mbresp);
    s_awvalid     = awv;
    s_wvalid      = wv;
    s_bready      = br;
    m_axi_awready = mawr;
    m_axi_wready  = mwr;
    m_axi_bvalid  = mbv;
    m_axi_bresp   = mbresp;
  endtask

  // Hold reset with requester 0 eligible; everything must stay quiet.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("reset wvalid",  64'(m_axi_wvalid),  64'd0);
    chk("reset awaddr",  64'(m_axi_awaddr),  64'd0);
    chk("reset wdata",   m_axi_wdata,        64'd0);
    chk("reset s_awready", 64'(s_awready),   64'd0);
    chk("reset m_bready",  64'(m_axi_bready), 64'd0);
    drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] awv, wv, br;
    logic       mawr, mwr, mbv;
    logic [1:0] mbresp;
    logic [1:0] e_rdy, e_bv;
    logic       e_awv, e_wv, e_mbr;
    logic [1:0] e_bresp;
    logic [0:0] e_gnt;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] awv, input logic [1:0] wv, input logic [1:0] br,
                              input logic mawr, input logic mwr, input logic mbv,
                              input logic [1:0] mbresp, input logic [1:0] e_rdy,
                              input logic [1:0] e_bv, input logic e_awv, input logic e_wv,
                              input logic e_mbr, input logic [1:0] e_bresp,
                              input logic [0:0] e_gnt);
    vec_t v;
    v.awv = awv; v.wv = wv; v.br = br; v.mawr = mawr; v.mwr = mwr; v.mbv = mbv;
    v.mbresp = mbresp; v.e_rdy = e_rdy; v.e_bv = e_bv; v.e_awv = e_awv; v.e_wv = e_wv;
    v.e_mbr = e_mbr; v.e_bresp = e_bresp; v.e_gnt = e_gnt;
    return v;
  endfunction

  vec_t vecs[$];

  // Randomized-phase model state.
  logic [N-1:0]       aw_on, w_on, br_r, elig, exp_oh;
  logic               in_flight, b_phase, bv_on, exp_awv, exp_wv;
  logic [GRANT_W-1:0] owner, pick;
  int unsigned        last_m;
  logic [AW-1:0]      exp_addr;
  logic [DW-1:0]      exp_data;
  logic [1:0]         bresp_r;
  int                 done_cnt;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_addr[0] = 48'h0000_2000_0000; req_data[0] = 64'h11;
    req_addr[1] = 48'h0000_3000_0040; req_data[1] = 64'h22;
    put_payload();
    do_reset();

    // awv wv br | mawr mwr mbv mbresp | e_rdy e_bv e_awv e_wv e_mbr e_bresp gnt
    vecs.push_back(mk(2'b01,2'b01,2'b11, 1,1,0,2'b00, 2'b01,2'b00, 0,0,0,2'b00, 0)); // single req0
    vecs.push_back(mk(2'b00,2'b00,2'b11, 1,1,0,2'b00, 2'b00,2'b00, 1,1,0,2'b00, 0));
    vecs.push_back(mk(2'b00,2'b00,2'b11, 0,0,1,2'b00, 2'b00,2'b01, 0,0,1,2'b00, 0));
    vecs.push_back(mk(2'b11,2'b11,2'b11, 0,0,0,2'b00, 2'b10,2'b00, 0,0,0,2'b00, 1)); // alternate
    vecs.push_back(mk(2'b01,2'b01,2'b11, 1,1,0,2'b00, 2'b00,2'b00, 1,1,0,2'b00, 1));
    vecs.push_back(mk(2'b01,2'b01,2'b11, 0,0,1,2'b00, 2'b00,2'b10, 0,0,1,2'b00, 1));
    vecs.push_back(mk(2'b11,2'b11,2'b11, 0,0,0,2'b00, 2'b01,2'b00, 0,0,0,2'b00, 0));
    vecs.push_back(mk(2'b10,2'b10,2'b11, 1,0,0,2'b00, 2'b00,2'b00, 1,1,0,2'b00, 0)); // W late
    vecs.push_back(mk(2'b10,2'b10,2'b11, 0,0,0,2'b00, 2'b00,2'b00, 0,1,0,2'b00, 0));
    vecs.push_back(mk(2'b10,2'b10,2'b11, 0,0,0,2'b00, 2'b00,2'b00, 0,1,0,2'b00, 0));
    vecs.push_back(mk(2'b10,2'b10,2'b11, 0,1,0,2'b00, 2'b00,2'b00, 0,1,0,2'b00, 0));
    vecs.push_back(mk(2'b10,2'b10,2'b11, 0,0,1,2'b00, 2'b00,2'b01, 0,0,1,2'b00, 0));
    vecs.push_back(mk(2'b10,2'b10,2'b11, 0,0,0,2'b00, 2'b10,2'b00, 0,0,0,2'b00, 1));
    vecs.push_back(mk(2'b00,2'b00,2'b11, 0,1,0,2'b00, 2'b00,2'b00, 1,1,0,2'b00, 1)); // AW late
    vecs.push_back(mk(2'b00,2'b00,2'b11, 0,0,0,2'b00, 2'b00,2'b00, 1,0,0,2'b00, 1));
    vecs.push_back(mk(2'b00,2'b00,2'b11, 0,0,0,2'b00, 2'b00,2'b00, 1,0,0,2'b00, 1));
    vecs.push_back(mk(2'b00,2'b00,2'b11, 1,0,0,2'b00, 2'b00,2'b00, 1,0,0,2'b00, 1));
    for (int k = 0; k < 4; k++)                                                        // SLVERR, bready low
      vecs.push_back(mk(2'b00,2'b00,2'b01, 0,0,1,2'b10, 2'b00,2'b10, 0,0,0,2'b10, 1));
    vecs.push_back(mk(2'b00,2'b00,2'b11, 0,0,1,2'b10, 2'b00,2'b10, 0,0,1,2'b10, 1));
    for (int k = 0; k < 5; k++)                                                        // AW only
      vecs.push_back(mk(2'b10,2'b00,2'b11, 0,0,0,2'b00, 2'b00,2'b00, 0,0,0,2'b00, 1));
    vecs.push_back(mk(2'b10,2'b10,2'b11, 0,0,0,2'b00, 2'b10,2'b00, 0,0,0,2'b00, 1));
    vecs.push_back(mk(2'b00,2'b00,2'b11, 1,1,0,2'b00, 2'b00,2'b00, 1,1,0,2'b00, 1));
    vecs.push_back(mk(2'b00,2'b00,2'b11, 0,0,1,2'b00, 2'b00,2'b10, 0,0,1,2'b00, 1));
    vecs.push_back(mk(2'b00,2'b00,2'b00, 0,0,0,2'b00, 2'b00,2'b00, 0,0,0,2'b00, 0));

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].awv, vecs[k].wv, vecs[k].br, vecs[k].mawr, vecs[k].mwr,
            vecs[k].mbv, vecs[k].mbresp);
      #1;
      chk($sformatf("v%0d s_awready", k), 64'(s_awready), 64'(vecs[k].e_rdy));
      chk($sformatf("v%0d s_wready", k),  64'(s_wready),  64'(vecs[k].e_rdy));
      chk($sformatf("v%0d s_bvalid", k),  64'(s_bvalid),  64'(vecs[k].e_bv));
      chk($sformatf("v%0d awvalid", k),   64'(m_axi_awvalid), 64'(vecs[k].e_awv));
      chk($sformatf("v%0d wvalid", k),    64'(m_axi_wvalid),  64'(vecs[k].e_wv));
      chk($sformatf("v%0d m_bready", k),  64'(m_axi_bready),  64'(vecs[k].e_mbr));
      if (vecs[k].e_bv != 2'b00)
        chk($sformatf("v%0d s_bresp", k), 64'(s_bresp), 64'(vecs[k].e_bresp));
      if (vecs[k].e_awv)
        chk($sformatf("v%0d awaddr", k), 64'(m_axi_awaddr), 64'(req_addr[vecs[k].e_gnt]));
      if (vecs[k].e_wv)
        chk($sformatf("v%0d wdata", k), m_axi_wdata, req_data[vecs[k].e_gnt]);
    end

    // Reset during ISSUE with requester 1 granted; requester 0 must win afterwards.
    @(negedge clk); drive(2'b01, 2'b01, 2'b11, 1, 1, 0, 2'b00); #1;
    chk("rst seq grant0", 64'(s_awready), 64'b01);
    @(negedge clk); drive(2'b00, 2'b00, 2'b11, 1, 1, 0, 2'b00);
    @(negedge clk); drive(2'b00, 2'b00, 2'b11, 0, 0, 1, 2'b00); #1;
    chk("rst seq b0", 64'(s_bvalid), 64'b01);
    @(negedge clk); drive(2'b11, 2'b11, 2'b11, 0, 0, 0, 2'b00); #1;
    chk("rst seq grant1", 64'(s_awready), 64'b10);
    @(negedge clk); drive(2'b01, 2'b01, 2'b11, 0, 0, 0, 2'b00); #1;
    chk("rst seq issue awvalid", 64'(m_axi_awvalid), 64'd1);
    chk("rst seq issue awaddr", 64'(m_axi_awaddr), 64'(req_addr[1]));
    #1 rst_n = 1'b0; #1;
    chk("mid rst awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("mid rst wvalid",  64'(m_axi_wvalid),  64'd0);
    @(negedge clk); #1;
    chk("mid rst s_awready", 64'(s_awready), 64'd0);
    rst_n = 1'b1; #1;
    chk("post rst grant", 64'(s_awready), 64'b01);
    @(negedge clk); drive(2'b00, 2'b00, 2'b11, 1, 1, 0, 2'b00); #1;
    chk("post rst awaddr", 64'(m_axi_awaddr), 64'(req_addr[0]));
    chk("post rst wdata", m_axi_wdata, req_data[0]);
    @(negedge clk); drive(2'b00, 2'b00, 2'b11, 0, 0, 1, 2'b00); #1;
    chk("post rst bvalid", 64'(s_bvalid), 64'b01);
    @(negedge clk); drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00);

    // Randomized traffic against the transaction-level model.
    do_reset();
    aw_on = '0; w_on = '0; br_r = '0;
    in_flight = 1'b0; b_phase = 1'b0; bv_on = 1'b0; exp_awv = 1'b0; exp_wv = 1'b0;
    owner = '0; pick = '0; last_m = N - 1; bresp_r = BRESP_OKAY; done_cnt = 0;
    exp_addr = '0; exp_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!aw_on[i] && !w_on[i]) begin
          if ($urandom_range(3) == 0) begin
            req_addr[i] = AW'({$urandom, $urandom});
            req_data[i] = {$urandom, $urandom};
            case ($urandom_range(2))
              0:       aw_on[i] = 1'b1;
              1:       w_on[i]  = 1'b1;
              default: begin aw_on[i] = 1'b1; w_on[i] = 1'b1; end
            endcase
          end
        end else begin
          if (!aw_on[i] && $urandom_range(2) == 0) aw_on[i] = 1'b1;
          if (!w_on[i]  && $urandom_range(2) == 0) w_on[i]  = 1'b1;
        end
        br_r[i] = 1'($urandom_range(1));
      end
      put_payload();
      m_axi_awready = 1'($urandom_range(1));
      m_axi_wready  = 1'($urandom_range(1));
      if (b_phase && !bv_on && $urandom_range(2) == 0) begin
        bv_on   = 1'b1;
        bresp_r = ($urandom_range(1) == 1) ? BRESP_SLVERR : BRESP_OKAY;
      end
      s_awvalid = aw_on; s_wvalid = w_on; s_bready = br_r;
      m_axi_bvalid = bv_on; m_axi_bresp = bresp_r;
      #1;

      // Expected winner: first eligible requester after the last one served.
      elig   = aw_on & w_on;
      exp_oh = '0;
      if (!in_flight) begin
        for (int unsigned k = 1; k <= N; k++) begin
          int unsigned c;
          c = (last_m + k) % N;
          if (exp_oh == '0 && bit_of(elig, c)) begin
            exp_oh = N'(1) << c;
            pick   = GRANT_W'(c);
          end
        end
      end
      chk($sformatf("rnd%0d s_awready", cyc), 64'(s_awready), 64'(exp_oh));
      chk($sformatf("rnd%0d s_wready", cyc),  64'(s_wready),  64'(exp_oh));
      chk($sformatf("rnd%0d awvalid", cyc),   64'(m_axi_awvalid), 64'(exp_awv));
      chk($sformatf("rnd%0d wvalid", cyc),    64'(m_axi_wvalid),  64'(exp_wv));
      if (exp_awv) chk($sformatf("rnd%0d awaddr", cyc), 64'(m_axi_awaddr), 64'(exp_addr));
      if (exp_wv)  chk($sformatf("rnd%0d wdata", cyc), m_axi_wdata, exp_data);
      chk($sformatf("rnd%0d s_bvalid", cyc), 64'(s_bvalid),
          64'((b_phase && bv_on) ? (N'(1) << owner) : N'(0)));
      chk($sformatf("rnd%0d m_bready", cyc), 64'(m_axi_bready),
          64'(b_phase && bit_of(br_r, 32'(owner))));
      if (b_phase && bv_on) chk($sformatf("rnd%0d s_bresp", cyc), 64'(s_bresp), 64'(bresp_r));

      // Advance the model by one cycle.
      if (b_phase) begin
        if (bv_on && bit_of(br_r, 32'(owner))) begin
          in_flight = 1'b0; b_phase = 1'b0; bv_on = 1'b0;
          last_m = 32'(owner);
          done_cnt++;
        end
      end else if (in_flight) begin
        if (exp_awv && m_axi_awready) exp_awv = 1'b0;
        if (exp_wv && m_axi_wready)   exp_wv  = 1'b0;
        if (!exp_awv && !exp_wv)      b_phase = 1'b1;
      end
      if (exp_oh != '0) begin
        owner = pick;
        exp_addr = req_addr[pick];
        exp_data = req_data[pick];
        aw_on &= ~exp_oh;
        w_on  &= ~exp_oh;
        in_flight = 1'b1; exp_awv = 1'b1; exp_wv = 1'b1;
      end
    end
    chk("random progress", 64'(done_cnt >= 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
